// File: rtl/amo_mem_sequencer_if.sv
// Bundle of the request, amo_unit, memory, snoop and response signals of the
// atomic memory sequencer. The sequencer uses the slave view; its environment uses master.
interface amo_mem_sequencer_if #(
    parameter int TAG_W = 6
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [63:0]      req_addr_i;
    logic [63:0]      req_data_i;
    logic [4:0]       req_funct5_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             amo_valid_o;
    logic [63:0]      amo_op_a_o;
    logic [63:0]      amo_op_b_o;
    logic [4:0]       amo_funct_o;
    logic             amo_ready_i;
    logic [63:0]      amo_result_i;
    logic             mem_req_valid_o;
    logic             mem_req_ready_i;
    logic             mem_req_we_o;
    logic [63:0]      mem_req_addr_o;
    logic [63:0]      mem_req_wdata_o;
    logic             mem_rsp_valid_i;
    logic [63:0]      mem_rsp_rdata_i;
    logic             inval_valid_i;
    logic [63:0]      inval_addr_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [63:0]      rsp_data_o;
    logic             rsp_err_o;
    logic [TAG_W-1:0] rsp_tag_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_funct5_i, req_tag_i,
        input  amo_ready_i, amo_result_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        input  inval_valid_i, inval_addr_i, rsp_ready_i,
        output req_ready_o, amo_valid_o, amo_op_a_o, amo_op_b_o, amo_funct_o,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
        output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_tag_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_funct5_i, req_tag_i,
        output amo_ready_i, amo_result_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        output inval_valid_i, inval_addr_i, rsp_ready_i,
        input  req_ready_o, amo_valid_o, amo_op_a_o, amo_op_b_o, amo_funct_o,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
        input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_tag_o
    );
endinterface

// File: rtl/amo_mem_sequencer.sv
// RV64A memory-side sequencer: LR.D / SC.D / AMO*.D read-modify-write with a
// single LR/SC reservation; one atomic in flight, all outputs registered.
module amo_mem_sequencer #(
    parameter int RESV_SHIFT = 6,
    parameter int TAG_W      = 6
) (
    input logic               clk,
    input logic               rst,
    amo_mem_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_EXEC, S_EXEC_WAIT, S_WR_REQ, S_WR_WAIT, S_RESP
    } state_t;

    localparam logic [4:0] F_LR = 5'h02;
    localparam logic [4:0] F_SC = 5'h03;

    state_t           state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      rs2_q, rs2_d;
    logic [63:0]      old_q, old_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic [63:0]      resv_line_q, resv_line_d;
    logic [4:0]       funct_q, funct_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             resv_valid_q, resv_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic             mem_req_we_q, mem_req_we_d;
    logic             amo_valid_q, amo_valid_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;

    logic funct_legal;
    logic req_misaligned;
    logic inval_hit;
    logic sc_resv_ok;
    logic amo_hits_resv;

    always_comb begin
        funct_legal = 1'b0;
        case (bus.req_funct5_i)
            5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08,
            5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C: funct_legal = 1'b1;
            default:                           funct_legal = 1'b0;
        endcase
    end

    assign req_misaligned = (bus.req_addr_i[2:0] != 3'b000);
    assign inval_hit      = bus.inval_valid_i && resv_valid_q &&
                            ((bus.inval_addr_i >> RESV_SHIFT) == resv_line_q);
    // A snoop landing in the SC accept cycle takes priority, so the SC fails.
    assign sc_resv_ok     = resv_valid_q && !inval_hit &&
                            ((bus.req_addr_i >> RESV_SHIFT) == resv_line_q);
    assign amo_hits_resv  = resv_valid_q && ((addr_q >> RESV_SHIFT) == resv_line_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        old_d        = old_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        resv_line_d  = resv_line_q;
        funct_d      = funct_q;
        tag_d        = tag_q;
        resv_valid_d = resv_valid_q && !inval_hit;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    rs2_d   = bus.req_data_i;
                    funct_d = bus.req_funct5_i;
                    tag_d   = bus.req_tag_i;
                    if (req_misaligned || !funct_legal) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 64'd0;
                    end else if (bus.req_funct5_i == F_SC) begin
                        resv_valid_d = 1'b0;
                        if (sc_resv_ok) begin
                            state_d = S_WR_REQ;
                            wdata_d = bus.req_data_i;
                        end else begin
                            state_d    = S_RESP;
                            rsp_data_d = 64'd1;
                        end
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (bus.mem_req_ready_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_rsp_valid_i) begin
                    old_d = bus.mem_rsp_rdata_i;
                    if (funct_q == F_LR) begin
                        resv_valid_d = 1'b1;
                        resv_line_d  = addr_q >> RESV_SHIFT;
                        rsp_data_d   = bus.mem_rsp_rdata_i;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: state_d = S_EXEC_WAIT;
            S_EXEC_WAIT: begin
                if (bus.amo_ready_i) begin
                    wdata_d = bus.amo_result_i;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (bus.mem_req_ready_i) begin
                    state_d = S_WR_WAIT;
                    if (funct_q != F_SC && amo_hits_resv) resv_valid_d = 1'b0;
                end
            end
            S_WR_WAIT: begin
                if (bus.mem_rsp_valid_i) begin
                    state_d    = S_RESP;
                    rsp_data_d = (funct_q == F_SC) ? 64'd0 : old_q;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d    = S_IDLE;
                    rsp_data_d = 64'd0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are decoded from the next state so they leave a flop.
        req_ready_d     = (state_d == S_IDLE);
        mem_req_valid_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        mem_req_we_d    = (state_d == S_WR_REQ);
        amo_valid_d     = (state_d == S_EXEC);
        rsp_valid_d     = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rs2_q           <= '0;
            old_q           <= '0;
            wdata_q         <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            resv_line_q     <= '0;
            resv_valid_q    <= 1'b0;
            funct_q         <= '0;
            tag_q           <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            amo_valid_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rs2_q           <= rs2_d;
            old_q           <= old_d;
            wdata_q         <= wdata_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            resv_line_q     <= resv_line_d;
            resv_valid_q    <= resv_valid_d;
            funct_q         <= funct_d;
            tag_q           <= tag_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            amo_valid_q     <= amo_valid_d;
            rsp_valid_q     <= rsp_valid_d;
        end
    end

    assign bus.req_ready_o     = req_ready_q;
    assign bus.amo_valid_o     = amo_valid_q;
    assign bus.amo_op_a_o      = old_q;
    assign bus.amo_op_b_o      = rs2_q;
    assign bus.amo_funct_o     = funct_q;
    assign bus.mem_req_valid_o = mem_req_valid_q;
    assign bus.mem_req_we_o    = mem_req_we_q;
    assign bus.mem_req_addr_o  = addr_q & ~64'h7;
    assign bus.mem_req_wdata_o = wdata_q;
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_data_o      = rsp_data_q;
    assign bus.rsp_err_o       = rsp_err_q;
    assign bus.rsp_tag_o       = tag_q;
endmodule

// File: tb/tb_amo_mem_sequencer.sv
// Directed bench for amo_mem_sequencer: transaction-level model of memory and
// reservation, a zero-wait memory/amo_unit environment and one per-cycle monitor.
module tb_amo_mem_sequencer;
    localparam logic [4:0] F_ADD  = 5'h00;
    localparam logic [4:0] F_SWAP = 5'h01;
    localparam logic [4:0] F_LR   = 5'h02;
    localparam logic [4:0] F_SC   = 5'h03;
    localparam logic [4:0] F_XOR  = 5'h04;
    localparam logic [4:0] F_MAXU = 5'h1C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    amo_mem_sequencer_if #(.TAG_W(6)) mif ();
    amo_mem_sequencer #(.RESV_SHIFT(6), .TAG_W(6)) dut (.clk(clk), .rst(rst), .bus(mif.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mm [logic [63:0]];
    logic [63:0] env_mem [logic [63:0]];
    bit          m_resv_v = 0;
    logic [63:0] m_resv_line = '0;

    logic        exp_rd, exp_wr, exp_amo, exp_err;
    logic [63:0] exp_addr, exp_wdata, exp_opa, exp_opb, exp_rdata;
    logic [4:0]  exp_funct;
    logic [5:0]  exp_tag;
    int          exp_lat;
    int          n_rd = 0, n_wr = 0, n_amo = 0, n_rsp = 0;
    logic [63:0] last_rsp_data;
    logic        last_rsp_err;
    int          last_lat;

    function automatic logic [63:0] amo_calc(logic [4:0] f, logic [63:0] a, logic [63:0] b);
        case (f)
            5'h00: return a + b;
            5'h01: return b;
            5'h04: return a ^ b;
            5'h08: return a | b;
            5'h0C: return a & b;
            5'h10: return ($signed(a) < $signed(b)) ? a : b;
            5'h14: return ($signed(a) > $signed(b)) ? a : b;
            5'h18: return (a < b) ? a : b;
            default: return (a > b) ? a : b;
        endcase
    endfunction

    function automatic logic [63:0] mm_rd(logic [63:0] a);
        return mm.exists(a) ? mm[a] : 64'd0;
    endfunction

    task automatic init_mem(input logic [63:0] a, input logic [63:0] v);
        mm[a] = v;
        env_mem[a] = v;
    endtask

    task automatic model_inval(input logic [63:0] a);
        if (m_resv_v && ((a >> 6) == m_resv_line)) m_resv_v = 0;
    endtask

    task automatic model_predict(input logic [63:0] a, input logic [63:0] d,
                                 input logic [4:0] f, input logic [5:0] t);
        logic [63:0] old;
        exp_tag = t; exp_rd = 0; exp_wr = 0; exp_amo = 0; exp_err = 0;
        exp_addr = a; exp_opb = d; exp_funct = f; exp_wdata = '0; exp_opa = '0;
        if (a[2:0] != 3'b000 || !(f inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08,
                                           5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C})) begin
            exp_err = 1; exp_rdata = 0; exp_lat = 1;
        end else if (f == F_LR) begin
            exp_rd = 1; exp_rdata = mm_rd(a); exp_lat = 3;
            m_resv_v = 1; m_resv_line = a >> 6;
        end else if (f == F_SC) begin
            if (m_resv_v && ((a >> 6) == m_resv_line)) begin
                exp_wr = 1; exp_wdata = d; mm[a] = d; exp_rdata = 0; exp_lat = 3;
            end else begin
                exp_rdata = 1; exp_lat = 1;
            end
            m_resv_v = 0;
        end else begin
            old = mm_rd(a);
            exp_rd = 1; exp_wr = 1; exp_amo = 1; exp_opa = old;
            exp_wdata = amo_calc(f, old, d); mm[a] = exp_wdata;
            exp_rdata = old; exp_lat = 7;
            if (m_resv_v && ((a >> 6) == m_resv_line)) m_resv_v = 0;
        end
    endtask

    // ---------------- environment: memory and amo_unit ----------------
    int          mem_stall = 0;
    bit          amo_hold = 0;
    bit          mem_pend = 0;
    logic [63:0] mem_rd_val = '0;
    bit          amo_pend = 0;
    logic [63:0] amo_res = '0;

    initial begin
        mif.mem_req_ready_i = 1'b1;
        mif.mem_rsp_valid_i = 1'b0;
        mif.mem_rsp_rdata_i = '0;
        forever begin
            @(negedge clk);
            mif.mem_rsp_valid_i = mem_pend;
            mif.mem_rsp_rdata_i = mem_pend ? mem_rd_val : 64'd0;
            mem_pend = 0;
            if (mif.mem_req_valid_o && mem_stall > 0) begin
                mif.mem_req_ready_i = 1'b0;
                mem_stall--;
            end else begin
                mif.mem_req_ready_i = 1'b1;
            end
            if (mif.mem_req_valid_o && mif.mem_req_ready_i) begin
                mem_pend = 1;
                if (mif.mem_req_we_o) env_mem[mif.mem_req_addr_o] = mif.mem_req_wdata_o;
                else mem_rd_val = env_mem.exists(mif.mem_req_addr_o) ? env_mem[mif.mem_req_addr_o] : 64'd0;
            end
        end
    end

    initial begin
        mif.amo_ready_i  = 1'b0;
        mif.amo_result_i = '0;
        forever begin
            @(negedge clk);
            mif.amo_ready_i  = amo_pend;
            mif.amo_result_i = amo_pend ? amo_res : 64'd0;
            amo_pend = mif.amo_valid_o && !amo_hold;
            amo_res  = amo_calc(mif.amo_funct_o, mif.amo_op_a_o, mif.amo_op_b_o);
        end
    end

    // ---------------- per-cycle monitor ----------------
    bit          p_mstall = 0, p_rstall = 0;
    logic        p_we;
    logic [63:0] p_maddr, p_wdata, p_rdata;
    logic        p_err;
    logic [5:0]  p_tag;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                p_mstall = 0; p_rstall = 0;
                continue;
            end
            if (p_mstall) begin
                chk("mem_hold_valid", {63'd0, mif.mem_req_valid_o}, 64'd1);
                chk("mem_hold_we", {63'd0, mif.mem_req_we_o}, {63'd0, p_we});
                chk("mem_hold_addr", mif.mem_req_addr_o, p_maddr);
                chk("mem_hold_wdata", mif.mem_req_wdata_o, p_wdata);
            end
            if (p_rstall) begin
                chk("rsp_hold_valid", {63'd0, mif.rsp_valid_o}, 64'd1);
                chk("rsp_hold_data", mif.rsp_data_o, p_rdata);
                chk("rsp_hold_err", {63'd0, mif.rsp_err_o}, {63'd0, p_err});
                chk("rsp_hold_tag", {58'd0, mif.rsp_tag_o}, {58'd0, p_tag});
            end
            if (mif.mem_req_valid_o && mif.mem_req_ready_i) begin
                chk("mem_addr", mif.mem_req_addr_o, exp_addr & ~64'h7);
                if (mif.mem_req_we_o) begin
                    n_wr++;
                    chk("mem_wr_allowed", {63'd0, exp_wr}, 64'd1);
                    chk("mem_wdata", mif.mem_req_wdata_o, exp_wdata);
                end else begin
                    n_rd++;
                    chk("mem_rd_allowed", {63'd0, exp_rd}, 64'd1);
                end
            end
            if (mif.amo_valid_o) begin
                n_amo++;
                chk("amo_op_a", mif.amo_op_a_o, exp_opa);
                chk("amo_op_b", mif.amo_op_b_o, exp_opb);
                chk("amo_funct", {59'd0, mif.amo_funct_o}, {59'd0, exp_funct});
            end
            if (mif.rsp_valid_o && mif.rsp_ready_i) begin
                n_rsp++;
                last_rsp_data = mif.rsp_data_o;
                last_rsp_err  = mif.rsp_err_o;
                chk("rsp_data", mif.rsp_data_o, exp_rdata);
                chk("rsp_err", {63'd0, mif.rsp_err_o}, {63'd0, exp_err});
                chk("rsp_tag", {58'd0, mif.rsp_tag_o}, {58'd0, exp_tag});
            end
            p_mstall = mif.mem_req_valid_o && !mif.mem_req_ready_i;
            p_we     = mif.mem_req_we_o;
            p_maddr  = mif.mem_req_addr_o;
            p_wdata  = mif.mem_req_wdata_o;
            p_rstall = mif.rsp_valid_o && !mif.rsp_ready_i;
            p_rdata  = mif.rsp_data_o;
            p_err    = mif.rsp_err_o;
            p_tag    = mif.rsp_tag_o;
        end
    end

    // ---------------- request driver ----------------
    task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic [4:0] f,
                          input logic [5:0] t, input int mstall, input int rstall,
                          input bit inv, input logic [63:0] inv_a);
        int lat;
        @(negedge clk);
        mem_stall = mstall;
        if (inv) begin
            mif.inval_valid_i = 1'b1;
            mif.inval_addr_i  = inv_a;
            model_inval(inv_a);
        end
        model_predict(a, d, f, t);
        n_rd = 0; n_wr = 0; n_amo = 0; n_rsp = 0;
        chk("req_ready_idle", {63'd0, mif.req_ready_o}, 64'd1);
        mif.req_valid_i  = 1'b1;
        mif.req_addr_i   = a;
        mif.req_data_i   = d;
        mif.req_funct5_i = f;
        mif.req_tag_i    = t;
        @(negedge clk);
        mif.req_valid_i   = 1'b0;
        mif.inval_valid_i = 1'b0;
        lat = 1;
        while (!mif.rsp_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        last_lat = lat;
        chk("latency", 64'(lat), 64'(exp_lat + mstall));
        repeat (rstall) @(negedge clk);
        mif.rsp_ready_i = 1'b1;
        @(negedge clk);
        mif.rsp_ready_i = 1'b0;
        chk("rsp_count", 64'(n_rsp), 64'd1);
        chk("rd_count", 64'(n_rd), {63'd0, exp_rd});
        chk("wr_count", 64'(n_wr), {63'd0, exp_wr});
        chk("amo_pulses", 64'(n_amo), {63'd0, exp_amo});
        chk("rsp_dropped", {63'd0, mif.rsp_valid_o}, 64'd0);
        $display("txn f=%02h addr=%h rs2=%h tag=%0d -> data=%h err=%0d lat=%0d",
                 f, a, d, t, last_rsp_data, last_rsp_err, lat);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] saved;
        int w;
        rst = 1'b1;
        mif.req_valid_i = 1'b0; mif.req_addr_i = '0; mif.req_data_i = '0;
        mif.req_funct5_i = '0; mif.req_tag_i = '0;
        mif.inval_valid_i = 1'b0; mif.inval_addr_i = '0; mif.rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {63'd0, mif.req_ready_o}, 64'd1);
        chk("reset_rsp_valid", {63'd0, mif.rsp_valid_o}, 64'd0);
        chk("reset_mem_valid", {63'd0, mif.mem_req_valid_o}, 64'd0);
        chk("reset_amo_valid", {63'd0, mif.amo_valid_o}, 64'd0);
        chk("reset_rsp_data", mif.rsp_data_o, 64'd0);

        init_mem(64'h1000, 64'd5);
        do_req(64'h1000, 64'd3, F_ADD, 6'd1, 0, 0, 0, '0);
        chk("amoadd_rsp_lit", last_rsp_data, 64'd5);
        chk("amoadd_mem_lit", env_mem[64'h1000], 64'd8);
        chk("amoadd_lat_lit", 64'(last_lat), 64'd7);

        init_mem(64'h2008, 64'hAB);
        do_req(64'h2008, 64'd0, F_LR, 6'd2, 0, 0, 0, '0);
        chk("lr_rsp_lit", last_rsp_data, 64'hAB);
        do_req(64'h2010, 64'd7, F_SC, 6'd3, 0, 0, 0, '0);
        chk("sc_ok_rsp_lit", last_rsp_data, 64'd0);
        chk("sc_ok_mem_lit", env_mem[64'h2010], 64'd7);
        do_req(64'h2010, 64'd9, F_SC, 6'd4, 0, 0, 0, '0);
        chk("sc_again_rsp_lit", last_rsp_data, 64'd1);
        chk("sc_again_lat_lit", 64'(last_lat), 64'd1);

        init_mem(64'h3000, 64'h11);
        do_req(64'h3000, 64'd0, F_LR, 6'd5, 0, 0, 0, '0);
        @(negedge clk);
        mif.inval_valid_i = 1'b1; mif.inval_addr_i = 64'h3020;
        model_inval(64'h3020);
        @(negedge clk);
        mif.inval_valid_i = 1'b0;
        do_req(64'h3000, 64'd9, F_SC, 6'd6, 0, 0, 0, '0);
        chk("sc_snoop_rsp_lit", last_rsp_data, 64'd1);
        chk("sc_snoop_mem_lit", env_mem[64'h3000], 64'h11);

        do_req(64'h4004, 64'd1, F_SWAP, 6'd7, 0, 0, 0, '0);
        chk("misalign_err_lit", {63'd0, last_rsp_err}, 64'd1);
        do_req(64'h4000, 64'd1, 5'h05, 6'd8, 0, 0, 0, '0);
        chk("illegal_err_lit", {63'd0, last_rsp_err}, 64'd1);

        init_mem(64'h4100, 64'h10);
        do_req(64'h4100, 64'hFFFF_FFFF_FFFF_FFF0, F_MAXU, 6'd9, 4, 3, 0, '0);
        chk("maxu_rsp_lit", last_rsp_data, 64'h10);
        chk("maxu_mem_lit", env_mem[64'h4100], 64'hFFFF_FFFF_FFFF_FFF0);
        chk("maxu_lat_lit", 64'(last_lat), 64'd11);

        init_mem(64'h7000, 64'h22);
        do_req(64'h7000, 64'd0, F_LR, 6'd10, 0, 0, 0, '0);
        do_req(64'h7000, 64'd4, F_SC, 6'd11, 0, 0, 1, 64'h7008);
        chk("sc_same_cycle_inval_lit", last_rsp_data, 64'd1);
        chk("sc_same_cycle_mem_lit", env_mem[64'h7000], 64'h22);

        init_mem(64'h7040, 64'd1);
        init_mem(64'h7048, 64'd10);
        do_req(64'h7040, 64'd0, F_LR, 6'd12, 0, 0, 0, '0);
        do_req(64'h7048, 64'd5, F_ADD, 6'd13, 0, 0, 0, '0);
        chk("amo_in_granule_mem_lit", env_mem[64'h7048], 64'd15);
        do_req(64'h7040, 64'd2, F_SC, 6'd14, 0, 0, 0, '0);
        chk("sc_after_amo_lit", last_rsp_data, 64'd1);

        init_mem(64'h8000, 64'hF0F0);
        do_req(64'h8000, 64'h0FF0, F_XOR, 6'd15, 0, 0, 0, '0);
        chk("xor_mem_lit", env_mem[64'h8000], 64'hFF00);

        // Reset while waiting on amo_unit: transaction and reservation are dropped.
        init_mem(64'h5000, 64'h55);
        do_req(64'h5000, 64'd0, F_LR, 6'd16, 0, 0, 0, '0);
        init_mem(64'h6000, 64'd3);
        @(negedge clk);
        amo_hold = 1;
        saved = mm_rd(64'h6000);
        model_predict(64'h6000, 64'd1, F_ADD, 6'd17);
        mm[64'h6000] = saved;
        n_rd = 0; n_wr = 0; n_amo = 0; n_rsp = 0;
        mif.req_valid_i = 1'b1; mif.req_addr_i = 64'h6000; mif.req_data_i = 64'd1;
        mif.req_funct5_i = F_ADD; mif.req_tag_i = 6'd17;
        @(negedge clk);
        mif.req_valid_i = 1'b0;
        w = 0;
        while (!mif.amo_valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_exec", {63'd0, mif.amo_valid_o}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_resv_v = 0;
        chk("abort_req_ready", {63'd0, mif.req_ready_o}, 64'd1);
        chk("abort_rsp_valid", {63'd0, mif.rsp_valid_o}, 64'd0);
        chk("abort_mem_valid", {63'd0, mif.mem_req_valid_o}, 64'd0);
        chk("abort_amo_valid", {63'd0, mif.amo_valid_o}, 64'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_rsp", 64'(n_rsp), 64'd0);
        chk("abort_no_write", 64'(n_wr), 64'd0);
        chk("abort_mem_lit", env_mem[64'h6000], 64'd3);
        amo_hold = 0;
        do_req(64'h5000, 64'd8, F_SC, 6'd18, 0, 0, 0, '0);
        chk("sc_after_reset_lit", last_rsp_data, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/amo_mem_sequencer.md
# amo_mem_sequencer

Memory-side sequencer for RV64A atomics, sitting between the load/store unit issue port and the data memory port. It performs LR.D, SC.D and the read-modify-write of every AMO*.D. For AMOs it drives the `amo_unit` compute interface, feeding it the loaded value and rs2, and writes the computed result back to memory. It also owns the single LR/SC reservation and returns rd data tagged to the issuing slot.

## Interface
Parameters:
- `RESV_SHIFT`, default 6: reservation granule is `addr[63:RESV_SHIFT]` (64-byte line).
- `TAG_W`, default 6: width of the request/response tag.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  atomic request valid.
- `req_ready_o`  out  1  sequencer idle, request accepted on valid&&ready.
- `req_addr_i`  in  64  byte address.
- `req_data_i`  in  64  rs2 value.
- `req_funct5_i`  in  5  funct5: LR=0x02, SC=0x03, AMOs 0x00/0x01/0x04/0x08/0x0C/0x10/0x14/0x18/0x1C.
- `req_tag_i`  in  TAG_W  returned unchanged on the response.
- `amo_valid_o`  out  1  one-cycle pulse to `amo_unit`.
- `amo_op_a_o`  out  64  loaded memory value.
- `amo_op_b_o`  out  64  rs2.
- `amo_funct_o`  out  5  funct5 passthrough.
- `amo_ready_i`  in  1  compute result valid (registered, one cycle after valid).
- `amo_result_i`  in  64  value to store.
- `mem_req_valid_o`  out  1  memory request.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_req_we_o`  out  1  1 = 64-bit write, 0 = read.
- `mem_req_addr_o`  out  64  doubleword address (`req_addr` with [2:0]=0).
- `mem_req_wdata_o`  out  64  store data.
- `mem_rsp_valid_i`  in  1  read data or write acknowledge.
- `mem_rsp_rdata_i`  in  64  read data.
- `inval_valid_i`  in  1  external invalidation/snoop.
- `inval_addr_i`  in  64  invalidated address.
- `rsp_valid_o`  out  1  response valid, held until `rsp_ready_i`.
- `rsp_ready_i`  in  1  consumer accepts response.
- `rsp_data_o`  out  64  rd value.
- `rsp_err_o`  out  1  misaligned address or illegal funct5.
- `rsp_tag_o`  out  TAG_W  tag of the request.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, EXEC, EXEC_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE: `req_ready_o`=1. On accept, latch addr, data, funct5 and tag, then:
  - misaligned (`addr[2:0]`≠0) or funct5 not in the legal set → RESP, `rsp_err_o`=1, `rsp_data_o`=0, no memory access.
  - LR → RD_REQ.
  - SC with a valid reservation matching the granule → WR_REQ, store rs2.
  - SC otherwise → RESP, data=1.
  - AMO → RD_REQ.
- RD_REQ: hold `mem_req_valid_o`, `we`=0 until ready; then go to RD_WAIT.
- RD_WAIT: on `mem_rsp_valid_i`, capture old value.
  - LR: set the reservation to the granule, go to RESP, data=old.
  - AMO: go to EXEC.
- EXEC: `amo_valid_o`=1 for exactly one cycle, with `op_a`=old and `op_b`=rs2; then EXEC_WAIT.
- EXEC_WAIT: on `amo_ready_i`, capture `amo_result_i`, go to WR_REQ.
- WR_REQ: hold write request with `wdata` = result (AMO) or rs2 (SC) until ready; then WR_WAIT.
- WR_WAIT: on ack, go to RESP. Data = old value (AMO) or 0 (SC success).
- RESP: hold `rsp_*` until `rsp_ready_i`, then IDLE.
- Reservation rules:
  - Any SC clears the reservation at accept.
  - An AMO write to the reserved granule clears it at WR_REQ handshake.
  - `inval_valid_i` with a matching granule clears it in the same cycle.
  - Invalidation in the SC accept cycle wins: the SC fails.
- `mem_rsp_valid_i` and `amo_ready_i` outside their wait states are ignored.

## Timing
- Reset: state IDLE, reservation invalid. `req_ready_o`=1; all other outputs 0.
- Reset mid-operation abandons the transaction: no response, reservation cleared. Memory side is reset together with this block.
- Accept→`rsp_valid_o` latency, with zero-wait memory (ready same cycle, rsp next cycle):
  - AMO: 7 cycles.
  - LR: 3 cycles.
  - SC success: 3 cycles.
  - SC fail or error: 1 cycle.
- Request, response and memory outputs are stable while valid and not ready.
- No pipelining: one atomic in flight; next accept is at earliest the cycle after the RESP handshake.
- Back-to-back LR then SC to the same granule, with no invalidation in between, must succeed.

## Test plan
- AMOADD at 0x1000, mem=5, rs2=3 → `amo_valid` pulse with op_a=5, op_b=3; memory write 8 @0x1000; rsp data=5; 7-cycle latency.
- LR 0x2008 (mem=0xAB) then SC 0x2010 rs2=7 → LR rsp 0xAB; SC writes 7, rsp data=0; second SC rsp data=1 with no write.
- LR 0x3000, `inval_valid_i`@0x3020, SC 0x3000 → SC fails: data=1, no memory write.
- AMOSWAP at 0x4004 → `rsp_err_o`=1, no `mem_req_valid_o`, 1-cycle latency.
- `mem_req_ready_i` low 4 cycles plus `rsp_ready_i` low 3 cycles on AMOMAXU → outputs held stable; result correct after stalls.
- `rst` asserted in EXEC_WAIT → next cycle IDLE, `req_ready_o`=1, no rsp, reservation invalid.
